// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline run controller: run-state encoding and
// default sizing of the enabled-cycle counter and the HALT drain.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_DONE = 2'b11
  } run_state_e;

  localparam int CNT_W_DEF        = 32;
  localparam int DRAIN_CYCLES_DEF = 3;
  localparam int DRAIN_W_DEF      = 2;

endpackage

// File: rtl/pipeline_run_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run/step/stop sequencer for the 5-stage pipeline: merges load-use stall,
// branch flush and HALT drain into the PC / IF-ID / ID-EX strobes.
module pipeline_run_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int DRAIN_W      = DRAIN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_step,
  input  logic             i_pause,
  input  logic             i_clear,
  input  logic             i_halt_detected,
  input  logic             i_load_hazard,
  input  logic             i_branch_taken,
  output logic             o_pipe_enable,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_bubble,
  output logic [1:0]       o_state,
  output logic             o_done,
  output logic [CNT_W-1:0] o_cycle_count
);

  run_state_e         state_q, state_d;
  logic               halted_q, halted_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               done_seen_q;
  logic               en;
  logic               halt_accept;
  logic               drain_last;
  logic               clear_done;

  assign en          = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign halt_accept = en && i_halt_detected && !i_load_hazard && !halted_q;
  assign drain_last  = en && halted_q && (drain_q == DRAIN_W'(1));
  assign clear_done  = (state_q == ST_DONE) && i_clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      halted_q    <= 1'b0;
      drain_q     <= '0;
      done_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      halted_q    <= halted_d;
      drain_q     <= drain_d;
      done_seen_q <= (state_q == ST_DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start)     state_d = ST_RUN;
        else if (i_step) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (drain_last)   state_d = ST_DONE;
        else if (i_pause) state_d = ST_IDLE;
      end
      ST_STEP: state_d = drain_last ? ST_DONE : ST_IDLE;
      ST_DONE: begin
        if (i_clear) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Drain only advances on enabled cycles, so pause/idle simply freezes it.
  always_comb begin
    halted_d = halted_q;
    drain_d  = drain_q;
    if (en && halted_q && (drain_q != '0)) begin
      drain_d = drain_q - DRAIN_W'(1);
    end
    if (halt_accept) begin
      halted_d = 1'b1;
      drain_d  = DRAIN_W'(DRAIN_CYCLES);
    end
    if (clear_done) begin
      halted_d = 1'b0;
      drain_d  = '0;
    end
  end

  // Load hazard outranks branch flush; a stalled branch re-resolves next cycle.
  always_comb begin
    o_pipe_enable  = en;
    o_pc_write     = en && !halted_q && !i_load_hazard;
    o_if_id_write  = en && !i_load_hazard;
    o_id_ex_bubble = en && i_load_hazard;
    o_if_id_flush  = en && !i_load_hazard && (i_branch_taken || halted_q);
    o_state        = state_q;
    o_done         = (state_q == ST_DONE) && !done_seen_q;
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cycle_cnt (
    .clk    (clk),
    .rst    (rst),
    .en_i   (en),
    .clr_i  (clear_done),
    .count_o(o_cycle_count)
  );

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Bench for pipeline_run_ctrl: directed scenarios, a cycle model checked on
// every falling edge, and literal spot checks at key points.
module tb_pipeline_run_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_start = 1'b0, i_step = 1'b0, i_pause = 1'b0, i_clear = 1'b0;
  logic i_halt_detected = 1'b0, i_load_hazard = 1'b0, i_branch_taken = 1'b0;

  logic        pipe_enable, pc_write, if_id_write, if_id_flush, id_ex_bubble, done;
  logic [1:0]  state;
  logic [31:0] cycle_count;

  logic        s_pipe_enable, s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_done;
  logic [1:0]  s_state;
  logic [2:0]  s_cycle_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_run_ctrl dut (
    .clk(clk), .rst(rst),
    .i_start(i_start), .i_step(i_step), .i_pause(i_pause), .i_clear(i_clear),
    .i_halt_detected(i_halt_detected), .i_load_hazard(i_load_hazard),
    .i_branch_taken(i_branch_taken),
    .o_pipe_enable(pipe_enable), .o_pc_write(pc_write), .o_if_id_write(if_id_write),
    .o_if_id_flush(if_id_flush), .o_id_ex_bubble(id_ex_bubble), .o_state(state),
    .o_done(done), .o_cycle_count(cycle_count)
  );

  // Narrow counter instance so saturation is reachable in a short run.
  pipeline_run_ctrl #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst),
    .i_start(i_start), .i_step(i_step), .i_pause(i_pause), .i_clear(i_clear),
    .i_halt_detected(i_halt_detected), .i_load_hazard(i_load_hazard),
    .i_branch_taken(i_branch_taken),
    .o_pipe_enable(s_pipe_enable), .o_pc_write(s_pc_write), .o_if_id_write(s_if_id_write),
    .o_if_id_flush(s_if_id_flush), .o_id_ex_bubble(s_id_ex_bubble), .o_state(s_state),
    .o_done(s_done), .o_cycle_count(s_cycle_count)
  );

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 run, 2 step, 3 done (the observable o_state values)
  int m_mode     = 0;
  bit m_halted   = 0;
  int m_drain    = 0;
  int m_enabled  = 0;
  bit m_done_new = 0;
  bit m_en, m_accept, m_last;
  int m_next;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_halted = 0; m_drain = 0; m_enabled = 0; m_done_new = 0;
    end else begin
      m_en     = (m_mode == 1) || (m_mode == 2);
      m_accept = m_en && i_halt_detected && !i_load_hazard && !m_halted;
      m_last   = m_en && m_halted && (m_drain == 1);
      if (m_en) m_enabled = m_enabled + 1;
      if (m_en && m_halted && m_drain > 0) m_drain = m_drain - 1;
      if (m_accept) begin m_halted = 1; m_drain = 3; end
      m_next = m_mode;
      case (m_mode)
        0: m_next = i_start ? 1 : (i_step ? 2 : 0);
        1: m_next = m_last ? 3 : (i_pause ? 0 : 1);
        2: m_next = m_last ? 3 : 0;
        default: if (i_clear) begin
          m_next = 0; m_halted = 0; m_drain = 0; m_enabled = 0;
        end
      endcase
      m_done_new = (m_next == 3) && (m_mode != 3);
      m_mode = m_next;
    end
  end

  logic [7:0]  exp_v, act_v;
  logic [31:0] exp_cnt;
  logic [2:0]  exp_sat;
  bit          e;

  always @(negedge clk) begin
    e = (m_mode == 1) || (m_mode == 2);
    exp_v = {e, e && !m_halted && !i_load_hazard, e && !i_load_hazard,
             e && !i_load_hazard && (i_branch_taken || m_halted), e && i_load_hazard,
             2'(m_mode), (m_mode == 3) && m_done_new};
    act_v = {pipe_enable, pc_write, if_id_write, if_id_flush, id_ex_bubble, state, done};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL strobes t=%0t got en/pc/ifid/flush/bub/state/done=%b want %b", $time, act_v, exp_v);
    end
    exp_cnt = 32'(m_enabled);
    n_cmp++;
    if (cycle_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL cycle_count t=%0t got %0d want %0d", $time, cycle_count, exp_cnt);
    end
    exp_sat = (m_enabled > 7) ? 3'd7 : 3'(m_enabled);
    n_cmp++;
    if ({s_pipe_enable, s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_state, s_done} !== exp_v
        || s_cycle_count !== exp_sat) begin
      n_fail++;
      $display("FAIL sat_inst t=%0t got cnt=%0d want %0d", $time, s_cycle_count, exp_sat);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    tick(2);
    rst = 1'b0;
    tick(1);
    check("reset_state", 32'(state), 0);
    check("reset_count", cycle_count, 0);
    check("reset_enable", 32'(pipe_enable), 0);

    // continuous run for 10 enabled cycles
    i_start = 1; tick(1); i_start = 0;
    tick(10);
    check("run10_count", cycle_count, 10);
    check("run10_state", 32'(state), 1);
    check("run10_pc_write", 32'(pc_write), 1);
    check("run10_sat_count", 32'(s_cycle_count), 7);

    // load hazard with branch: stall wins, branch flushes the next cycle
    i_load_hazard = 1; i_branch_taken = 1; #1;
    check("haz_pc_write", 32'(pc_write), 0);
    check("haz_if_id_write", 32'(if_id_write), 0);
    check("haz_bubble", 32'(id_ex_bubble), 1);
    check("haz_flush", 32'(if_id_flush), 0);
    tick(1); i_load_hazard = 0; #1;
    check("branch_flush", 32'(if_id_flush), 1);
    tick(1); i_branch_taken = 0;
    i_pause = 1; tick(1); i_pause = 0;
    check("pause_state", 32'(state), 0);
    check("pause_count", cycle_count, 13);

    // three single steps with gaps
    do_reset();
    for (int k = 0; k < 3; k++) begin
      i_step = 1; tick(1); i_step = 0;
      check("step_enable", 32'(pipe_enable), 1);
      check("step_state", 32'(state), 2);
      tick(1);
      check("step_back_idle", 32'(state), 0);
      tick(2);
    end
    check("step3_count", cycle_count, 3);

    // clear ignored in IDLE, start beats step, step ignored in RUN
    i_clear = 1; tick(1); i_clear = 0;
    check("idle_clear_ignored", cycle_count, 3);
    i_start = 1; i_step = 1; tick(1); i_start = 0;
    check("start_wins", 32'(state), 1);
    tick(1); i_step = 0;
    check("run_ignores_step", 32'(state), 1);
    i_pause = 1; tick(1); i_pause = 0;
    check("misc_count", cycle_count, 5);

    // HALT in run at enabled cycle 6
    do_reset();
    i_start = 1; tick(1); i_start = 0;
    tick(5);
    i_halt_detected = 1; tick(1); i_halt_detected = 0;
    check("drain_pc_write", 32'(pc_write), 0);
    check("drain_flush", 32'(if_id_flush), 1);
    tick(3);
    check("halt_done_state", 32'(state), 3);
    check("halt_done_pulse", 32'(done), 1);
    check("halt_done_count", cycle_count, 9);
    tick(1);
    check("done_one_cycle", 32'(done), 0);
    i_clear = 1; tick(1); i_clear = 0;
    check("clear_state", 32'(state), 0);
    check("clear_count", cycle_count, 0);

    // HALT accepted while stepping
    i_step = 1; tick(1); i_step = 0;
    i_halt_detected = 1; tick(1); i_halt_detected = 0;
    for (int k = 0; k < 3; k++) begin
      check("step_drain_not_done", 32'(state), 0);
      i_step = 1; tick(1); i_step = 0;
      tick(1);
    end
    check("step_halt_done", 32'(state), 3);
    check("step_halt_pulse", 32'(done), 1);
    check("step_halt_count", cycle_count, 4);
    i_step = 1; tick(1); i_step = 0;
    check("done_ignores_step", 32'(pipe_enable), 0);
    i_clear = 1; tick(1); i_clear = 0;
    check("step_clear_count", cycle_count, 0);

    // pause mid-drain freezes the drain, a step finishes it
    i_start = 1; tick(1); i_start = 0;
    i_halt_detected = 1; tick(1); i_halt_detected = 0;
    tick(1);
    i_pause = 1; tick(1); i_pause = 0;
    tick(3);
    check("frozen_drain_idle", 32'(state), 0);
    i_step = 1; tick(1); i_step = 0;
    tick(1);
    check("resumed_drain_done", 32'(state), 3);
    i_clear = 1; tick(1); i_clear = 0;

    // stalled HALT, then reset mid-drain
    i_start = 1; tick(1); i_start = 0;
    i_load_hazard = 1; i_halt_detected = 1; tick(1); i_load_hazard = 0;
    tick(1); i_halt_detected = 0;
    check("stalled_halt_flush", 32'(if_id_flush), 1);
    check("stalled_halt_count", cycle_count, 2);
    tick(1);
    rst = 1; #1;
    check("rst_state", 32'(state), 0);
    check("rst_enable", 32'(pipe_enable), 0);
    tick(1); rst = 0;
    i_start = 1; tick(1); i_start = 0;
    check("fresh_pc_write", 32'(pc_write), 1);
    check("fresh_state", 32'(state), 1);
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
